// File: rtl/fetch_pkg.sv
// Shared types and constants for the RV64 instruction fetch stage.
// Holds the fetch FSM state enum, the nop encoding and instruction size.
package fetch_pkg;

   typedef enum logic [2:0] {
      S_IDLE,
      S_REQ,
      S_WAIT,
      S_HOLD,
      S_FLUSH
   } fetch_state_t;

   localparam logic [31:0] INSTR_NOP   = 32'h0000_0013;
   localparam int unsigned INSTR_BYTES = 4;

endpackage

// File: rtl/fetch_pc_next.sv
// Next-PC select for the fetch stage: redirect, then pc+4, else hold.
// Ports: pc, advance, redirect_valid, redirect_pc in; pc_next out.
import fetch_pkg::*;

module fetch_pc_next (
   input  logic [63:0] pc,
   input  logic        advance,
   input  logic        redirect_valid,
   input  logic [63:0] redirect_pc,
   output logic [63:0] pc_next
);

   always_comb begin
      pc_next = pc;
      if (redirect_valid)
         pc_next = redirect_pc;
      else if (advance)
         pc_next = pc + 64'(INSTR_BYTES);
   end

endmodule

// File: rtl/fetch_stage.sv
// RV64 fetch stage: one outstanding imem request, valid/ready to decode,
// redirect with stale-response flush. Optional FETCH_MISALIGN_CHECK_EN.
// Ports: clk, rst_n; ireq_valid/addr/ready; iresp_valid/data;
// redirect_valid/pc; out_valid/ready/pc/instr/misalign.
import fetch_pkg::*;

module fetch_stage #(
   parameter logic [63:0] RESET_PC = 64'h0000_0000_8000_0000
) (
   input  logic        clk,
   input  logic        rst_n,
   output logic        ireq_valid,
   output logic [63:0] ireq_addr,
   input  logic        ireq_ready,
   input  logic        iresp_valid,
   input  logic [31:0] iresp_data,
   input  logic        redirect_valid,
   input  logic [63:0] redirect_pc,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [63:0] out_pc,
   output logic [31:0] out_instr,
   output logic        out_misalign
);

   fetch_state_t state;
   fetch_state_t state_next;
   logic [63:0]  pc;
   logic [63:0]  pc_next;
   logic         fault;
   logic         advance;
   logic         load_resp;
   logic         load_fault;
   logic         clr_out;

`ifdef FETCH_MISALIGN_CHECK_EN
   assign fault = (state == S_REQ) && (pc[1:0] != 2'b00);
`else
   assign fault = 1'b0;
`endif

   // A faulting PC never reaches memory.
   assign ireq_valid = (state == S_REQ) && !fault;
   assign ireq_addr  = pc;

   always_comb begin
      state_next = state;
      advance    = 1'b0;
      load_resp  = 1'b0;
      load_fault = 1'b0;
      clr_out    = 1'b0;
      case (state)
         S_IDLE: state_next = S_REQ;
         S_REQ: begin
            if (redirect_valid) begin
               // An accepted request to the old PC is still owed.
               if (ireq_valid && ireq_ready)
                  state_next = S_FLUSH;
            end else if (fault) begin
               load_fault = 1'b1;
               state_next = S_HOLD;
            end else if (ireq_ready) begin
               state_next = S_WAIT;
            end
         end
         S_WAIT: begin
            if (iresp_valid) begin
               state_next = redirect_valid ? S_REQ : S_HOLD;
               load_resp  = !redirect_valid;
               advance    = !redirect_valid;
            end else if (redirect_valid) begin
               state_next = S_FLUSH;
            end
         end
         S_HOLD: begin
            if (redirect_valid || out_ready) begin
               clr_out    = 1'b1;
               state_next = S_REQ;
            end
         end
         S_FLUSH: begin
            if (iresp_valid && !redirect_valid)
               state_next = S_REQ;
         end
         default: state_next = S_IDLE;
      endcase
   end

   fetch_pc_next u_pc_next (
      .pc             (pc),
      .advance        (advance),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc),
      .pc_next        (pc_next)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         state <= S_IDLE;
      else
         state <= state_next;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         pc <= RESET_PC;
      else
         pc <= pc_next;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid <= 1'b0;
         out_pc    <= '0;
         out_instr <= '0;
      end else if (load_resp) begin
         out_valid <= 1'b1;
         out_pc    <= pc;
         out_instr <= iresp_data;
      end else if (load_fault) begin
         out_valid <= 1'b1;
         out_pc    <= pc;
         out_instr <= INSTR_NOP;
      end else if (clr_out) begin
         out_valid <= 1'b0;
      end
   end

`ifdef FETCH_MISALIGN_CHECK_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         out_misalign <= 1'b0;
      else if (load_fault)
         out_misalign <= 1'b1;
      else if (load_resp || clr_out)
         out_misalign <= 1'b0;
   end
`else
   assign out_misalign = 1'b0;
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: directed vector table, hand sequences for
// misalign and mid-run reset, then random traffic against a model.
module tb_fetch_stage;

`ifdef FETCH_MISALIGN_CHECK_EN
   localparam bit CHK = 1'b1;
`else
   localparam bit CHK = 1'b0;
`endif
   localparam logic [63:0] RPC = 64'h0000_0000_8000_0000;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        ireq_valid;
   logic [63:0] ireq_addr;
   logic        ireq_ready = 1'b0;
   logic        iresp_valid = 1'b0;
   logic [31:0] iresp_data = '0;
   logic        redirect_valid = 1'b0;
   logic [63:0] redirect_pc = '0;
   logic        out_valid;
   logic        out_ready = 1'b0;
   logic [63:0] out_pc;
   logic [31:0] out_instr;
   logic        out_misalign;

   int vectors = 0;
   int miscompares = 0;

   always #5 clk = ~clk;

   fetch_stage dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .ireq_valid     (ireq_valid),
      .ireq_addr      (ireq_addr),
      .ireq_ready     (ireq_ready),
      .iresp_valid    (iresp_valid),
      .iresp_data     (iresp_data),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc),
      .out_valid      (out_valid),
      .out_ready      (out_ready),
      .out_pc         (out_pc),
      .out_instr      (out_instr),
      .out_misalign   (out_misalign)
   );

   typedef struct {
      logic        rdy;
      logic        rv;
      logic [31:0] rd;
      logic        redir;
      logic [63:0] rpc;
      logic        ordy;
      logic        e_iv;
      logic [63:0] e_addr;
      logic        e_ov;
      logic [63:0] e_pc;
      logic [31:0] e_ins;
   } vec_t;

   vec_t tbl[$];

   task automatic chk(input string nm, input logic [63:0] act,
                      input logic [63:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %h expected %h at %0t", nm, act, exp,
                  $time);
      end
   endtask

   task automatic add(input logic rdy, input logic rv, input logic [31:0] rd,
                      input logic redir, input logic [63:0] rpc,
                      input logic ordy, input logic e_iv,
                      input logic [63:0] e_addr, input logic e_ov,
                      input logic [63:0] e_pc, input logic [31:0] e_ins);
      vec_t v;
      v.rdy = rdy; v.rv = rv; v.rd = rd; v.redir = redir; v.rpc = rpc;
      v.ordy = ordy; v.e_iv = e_iv; v.e_addr = e_addr; v.e_ov = e_ov;
      v.e_pc = e_pc; v.e_ins = e_ins;
      tbl.push_back(v);
   endtask

   task automatic drive(input logic rdy, input logic rv, input logic [31:0] rd,
                        input logic redir, input logic [63:0] rpc,
                        input logic ordy);
      ireq_ready     = rdy;
      iresp_valid    = rv;
      iresp_data     = rd;
      redirect_valid = redir;
      redirect_pc    = rpc;
      out_ready      = ordy;
   endtask

   task automatic step(input logic rdy, input logic rv, input logic [31:0] rd,
                       input logic redir, input logic [63:0] rpc,
                       input logic ordy);
      drive(rdy, rv, rd, redir, rpc, ordy);
      @(negedge clk);
      #1;
   endtask

   task automatic chk_reset_vals(input string tag);
      chk({tag, "_ireq_valid"}, 64'(ireq_valid), 64'd0);
      chk({tag, "_ireq_addr"}, ireq_addr, RPC);
      chk({tag, "_out_valid"}, 64'(out_valid), 64'd0);
      chk({tag, "_out_pc"}, out_pc, 64'd0);
      chk({tag, "_out_instr"}, 64'(out_instr), 64'd0);
      chk({tag, "_out_misalign"}, 64'(out_misalign), 64'd0);
   endtask

   // Transaction-level reference: what is owed by memory, what is
   // parked for decode, and where fetch will go next.
   logic        m_boot;
   logic [63:0] m_pc;
   logic        m_pend;
   logic        m_stale;
   logic        m_have;
   logic [63:0] m_opc;
   logic [31:0] m_oins;
   logic        m_omis;

   function automatic logic m_fault();
      return CHK && (m_pc[1:0] != 2'b00);
   endfunction

   function automatic logic m_req();
      return !m_boot && !m_pend && !m_have && !m_fault();
   endfunction

   task automatic model_reset();
      m_boot = 1'b1; m_pc = RPC; m_pend = 1'b0; m_stale = 1'b0;
      m_have = 1'b0; m_opc = '0; m_oins = '0; m_omis = 1'b0;
   endtask

   task automatic model_step(input logic rdy, input logic rv,
                             input logic [31:0] rd, input logic redir,
                             input logic [63:0] rpc, input logic ordy);
      logic issued;
      logic idle_req;
      issued   = m_req() && rdy;
      idle_req = !m_boot && !m_pend && !m_have;
      if (m_boot) begin
         m_boot = 1'b0;
         if (redir) m_pc = rpc;
      end else if (redir) begin
         if (m_have) begin
            m_have = 1'b0; m_omis = 1'b0;
         end else if (m_pend) begin
            if (!m_stale) begin
               if (rv) m_pend = 1'b0;
               else m_stale = 1'b1;
            end
         end else if (issued) begin
            m_pend = 1'b1; m_stale = 1'b1;
         end
         m_pc = rpc;
      end else if (m_have) begin
         if (ordy) begin
            m_have = 1'b0; m_omis = 1'b0;
         end
      end else if (m_pend) begin
         if (rv) begin
            if (!m_stale) begin
               m_have = 1'b1; m_opc = m_pc; m_oins = rd;
               m_pc = m_pc + 64'd4;
            end
            m_pend = 1'b0; m_stale = 1'b0;
         end
      end else if (idle_req && m_fault()) begin
         m_have = 1'b1; m_omis = 1'b1; m_opc = m_pc;
         m_oins = 32'h0000_0013;
      end else if (issued) begin
         m_pend = 1'b1; m_stale = 1'b0;
      end
   endtask

   initial begin
      logic        owed;
      int          cnt;
      logic        rdy, rv, redir, ordy, e_iv, acc;
      logic [31:0] rd;
      logic [63:0] rpc;

      // cycle-by-cycle directed run from reset release
      add(1, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0);
      add(1, 0, 0, 0, 0, 0,  1, RPC, 0, 0, 0);
      add(0, 1, 32'h00a00093, 0, 0, 0,  0, 0, 0, 0, 0);
      for (int i = 0; i < 5; i++)
         add(0, 0, 0, 0, 0, 0,  0, 0, 1, RPC, 32'h00a00093);
      add(0, 0, 0, 0, 0, 1,  0, 0, 1, RPC, 32'h00a00093);
      add(1, 0, 0, 0, 0, 0,  1, 64'h8000_0004, 0, 0, 0);
      add(0, 0, 0, 1, 64'h8000_0100, 0,  0, 0, 0, 0, 0);
      add(0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0);
      add(0, 1, 32'hdeadbeef, 0, 0, 0,  0, 0, 0, 0, 0);
      add(1, 0, 0, 1, 64'h8000_0200, 0,  1, 64'h8000_0100, 0, 0, 0);
      add(0, 1, 32'hbad0bad0, 0, 0, 0,  0, 0, 0, 0, 0);
      add(1, 0, 0, 0, 0, 0,  1, 64'h8000_0200, 0, 0, 0);
      add(0, 1, 32'h11111111, 0, 0, 0,  0, 0, 0, 0, 0);
      add(0, 0, 0, 1, 64'h8000_0300, 1,
          0, 0, 1, 64'h8000_0200, 32'h11111111);
      add(0, 0, 0, 0, 0, 0,  1, 64'h8000_0300, 0, 0, 0);
      add(0, 0, 0, 1, 64'hffff_ffff_ffff_fffc, 0,
          1, 64'h8000_0300, 0, 0, 0);
      add(1, 0, 0, 0, 0, 0,  1, 64'hffff_ffff_ffff_fffc, 0, 0, 0);
      add(0, 1, 32'h00000022, 0, 0, 0,  0, 0, 0, 0, 0);
      add(0, 0, 0, 0, 0, 1,
          0, 0, 1, 64'hffff_ffff_ffff_fffc, 32'h00000022);
      add(0, 0, 0, 1, 64'h8000_0102, 0,  1, 64'd0, 0, 0, 0);

      repeat (3) @(negedge clk);
      #1;
      chk_reset_vals("reset");
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      foreach (tbl[i]) begin
         chk($sformatf("t%0d_ireq_valid", i), 64'(ireq_valid),
             64'(tbl[i].e_iv));
         if (tbl[i].e_iv)
            chk($sformatf("t%0d_ireq_addr", i), ireq_addr, tbl[i].e_addr);
         chk($sformatf("t%0d_out_valid", i), 64'(out_valid),
             64'(tbl[i].e_ov));
         if (tbl[i].e_ov) begin
            chk($sformatf("t%0d_out_pc", i), out_pc, tbl[i].e_pc);
            chk($sformatf("t%0d_out_instr", i), 64'(out_instr),
                64'(tbl[i].e_ins));
         end
         chk($sformatf("t%0d_out_misalign", i), 64'(out_misalign), 64'd0);
         step(tbl[i].rdy, tbl[i].rv, tbl[i].rd, tbl[i].redir, tbl[i].rpc,
              tbl[i].ordy);
      end

      // misaligned redirect target
`ifdef FETCH_MISALIGN_CHECK_EN
      chk("mis_noreq", 64'(ireq_valid), 64'd0);
      step(1, 0, 0, 0, 0, 0);
      chk("mis_noreq2", 64'(ireq_valid), 64'd0);
      chk("mis_valid", 64'(out_valid), 64'd1);
      chk("mis_flag", 64'(out_misalign), 64'd1);
      chk("mis_instr", 64'(out_instr), 64'h13);
      chk("mis_pc", out_pc, 64'h8000_0102);
      step(0, 0, 0, 0, 0, 1);
      chk("mis_clr", 64'(out_misalign), 64'd0);
      chk("mis_refault", 64'(ireq_valid), 64'd0);
      step(0, 0, 0, 1, 64'h8000_0200, 0);
      chk("mis_exit_valid", 64'(ireq_valid), 64'd1);
      chk("mis_exit_addr", ireq_addr, 64'h8000_0200);
`else
      chk("mis_req", 64'(ireq_valid), 64'd1);
      chk("mis_addr", ireq_addr, 64'h8000_0102);
      step(1, 0, 0, 0, 0, 0);
      step(0, 1, 32'h00000033, 0, 0, 0);
      chk("mis_valid", 64'(out_valid), 64'd1);
      chk("mis_flag", 64'(out_misalign), 64'd0);
      chk("mis_pc", out_pc, 64'h8000_0102);
      step(0, 0, 0, 0, 0, 1);
      chk("mis_next", ireq_addr, 64'h8000_0106);
`endif

      // reset mid-cycle takes effect without a clock edge
      step(1, 0, 0, 0, 0, 0);
      step(0, 1, 32'h44444444, 0, 0, 0);
      drive(0, 0, 0, 0, 0, 0);
      #1;
      rst_n = 1'b0;
      #1;
      chk_reset_vals("midrst");
      @(negedge clk);
      rst_n = 1'b1;

      // random traffic against the model
      model_reset();
      owed = 1'b0;
      cnt = 0;
      #1;
      for (int c = 0; c < 4000; c++) begin
         e_iv = m_req();
         chk("rnd_ireq_valid", 64'(ireq_valid), 64'(e_iv));
         if (e_iv) chk("rnd_ireq_addr", ireq_addr, m_pc);
         chk("rnd_out_valid", 64'(out_valid), 64'(m_have));
         chk("rnd_out_pc", out_pc, m_opc);
         chk("rnd_out_instr", 64'(out_instr), 64'(m_oins));
         chk("rnd_out_misalign", 64'(out_misalign), 64'(m_omis));

         rdy  = ($urandom_range(0, 9) < 6);
         ordy = $urandom_range(0, 1) == 1;
         rd   = $urandom;
         rv   = owed ? (cnt == 0) : ($urandom_range(0, 19) == 0);
         redir = ($urandom_range(0, 11) == 0) && !(rv && m_pend && m_stale);
         case ($urandom_range(0, 7))
            0: rpc = 64'hffff_ffff_ffff_fff8;
            1: rpc = {32'h0, $urandom} | 64'h2;
            default: rpc = {32'h0, $urandom} & ~64'h3;
         endcase
         acc = e_iv && rdy;
         if (owed) begin
            if (rv) owed = 1'b0;
            else cnt--;
         end
         if (acc) begin
            owed = 1'b1;
            cnt  = $urandom_range(0, 3);
         end
         model_step(rdy, rv, rd, redir, rpc, ordy);
         step(rdy, rv, rd, redir, rpc, ordy);
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors,
               miscompares);
      $finish;
   end

endmodule
